// File: rtl/seven_seg_scan_receiver_if.sv
// Pin bundle between a multiplexed 7-segment scanner and its receiver.
// master drives the display pins, slave decodes them.
interface seven_seg_scan_receiver_if;
  logic        DIG_1;
  logic        DIG_2;
  logic        DIG_3;
  logic        DIG_4;
  logic [6:0]  LIGHT_SEG;
  logic        DP;
  logic [3:0]  M_HI;
  logic [3:0]  M_LO;
  logic [3:0]  S_HI;
  logic [3:0]  S_LO;
  logic [12:0] SEC_TOTAL;
  logic        FRAME_VALID;
  logic        VALUE_CHANGED;
  logic        DECODE_ERR;
  logic        SCAN_ERR;
  logic        SCAN_LOST;

  modport master (
    output DIG_1, DIG_2, DIG_3, DIG_4, LIGHT_SEG, DP,
    input  M_HI, M_LO, S_HI, S_LO, SEC_TOTAL,
    input  FRAME_VALID, VALUE_CHANGED,
    input  DECODE_ERR, SCAN_ERR, SCAN_LOST
  );

  modport slave (
    input  DIG_1, DIG_2, DIG_3, DIG_4, LIGHT_SEG, DP,
    output M_HI, M_LO, S_HI, S_LO, SEC_TOTAL,
    output FRAME_VALID, VALUE_CHANGED,
    output DECODE_ERR, SCAN_ERR, SCAN_LOST
  );
endinterface

// File: rtl/seven_seg_scan_receiver.sv
// Samples a scanned 7-segment display, waits for each digit to settle,
// decodes it to BCD and commits coherent MM:SS frames.
module seven_seg_scan_receiver #(
  parameter logic [7:0]  SETTLE_CYC  = 8'd4,
  parameter logic [19:0] TIMEOUT_CYC = 20'h01000,
  parameter logic        SEG_ACTIVE  = 1'b1
) (
  input logic                       CLK,
  input logic                       RES_X,
  seven_seg_scan_receiver_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_e;

  logic [3:0]      dig_q;
  logic [6:0]      seg_q;
  logic            dp_q;
  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      pat_q, pat_d;
  logic            cap;
  logic [3:0][3:0] slot_q, slot_d;
  logic [3:0]      sdp_q, sdp_d;
  logic [3:0]      flag_q, flag_d;
  logic [3:0]      all_f;
  logic            pend_q, pend_d;
  logic [19:0]     to_q, to_d;
  logic            lost_set;
  logic            first_q;
  logic [3:0]      mh_q, ml_q, sh_q, sl_q;
  logic [12:0]     sec_q;
  logic            fv_q, vc_q, derr_q, serr_q, lost_q;
  logic            s_none, s_one, s_multi, same;
  logic [1:0]      s_idx;
  logic            ok;
  logic [12:0]     sec_c;
  logic            chg, derr_c;

  function automatic logic [3:0] dec(input logic [6:0] s);
    case (s)
      7'h3F:   dec = 4'd0;
      7'h06:   dec = 4'd1;
      7'h5B:   dec = 4'd2;
      7'h4F:   dec = 4'd3;
      7'h66:   dec = 4'd4;
      7'h6D:   dec = 4'd5;
      7'h7D:   dec = 4'd6;
      7'h07:   dec = 4'd7;
      7'h7F:   dec = 4'd8;
      7'h6F:   dec = 4'd9;
      7'h00:   dec = 4'hF;
      default: dec = 4'hE;
    endcase
  endfunction

  // Register the pins once; segments normalised to lit-high.
  always_ff @(posedge CLK) begin
    if (!RES_X) begin
      dig_q <= 4'd0;
      seg_q <= 7'd0;
      dp_q  <= 1'b0;
    end else begin
      dig_q <= {bus.DIG_4, bus.DIG_3, bus.DIG_2, bus.DIG_1};
      seg_q <= bus.LIGHT_SEG ^ {7{~SEG_ACTIVE}};
      dp_q  <= bus.DP;
    end
  end

  assign s_none  = (dig_q == 4'd0);
  assign s_one   = $onehot(dig_q);
  assign s_multi = !s_none && !s_one;
  assign same    = (s_idx == idx_q) && (seg_q == pat_q);

  // Index of the single active strobe.
  always_comb begin
    s_idx = 2'd0;
    if (s_one) begin
      unique case (1'b1)
        dig_q[0]: s_idx = 2'd0;
        dig_q[1]: s_idx = 2'd1;
        dig_q[2]: s_idx = 2'd2;
        dig_q[3]: s_idx = 2'd3;
      endcase
    end
  end

  // Settle FSM state register.
  always_ff @(posedge CLK) begin
    if (!RES_X) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 2'd0;
      pat_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
    end
  end

  // Settle FSM next state: count identical samples, capture once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    cap     = 1'b0;
    if (!s_one) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else if (state_q == IDLE || !same) begin
      state_d = SETTLE;
      cnt_d   = 8'd1;
      idx_d   = s_idx;
      pat_d   = seg_q;
    end else if (state_q == SETTLE) begin
      if (cnt_q >= SETTLE_CYC) begin
        cap     = 1'b1;
        state_d = HELD;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Frame slots, timeout and commit request.
  always_comb begin
    slot_d   = slot_q;
    sdp_d    = sdp_q;
    flag_d   = flag_q;
    pend_d   = 1'b0;
    to_d     = to_q;
    all_f    = flag_q;
    lost_set = 1'b0;
    if (cap) begin
      slot_d[idx_q] = dec(pat_q);
      sdp_d[idx_q]  = dp_q;
      all_f[idx_q]  = 1'b1;
      to_d          = 20'd0;
      if (all_f == 4'hF) begin
        flag_d = 4'd0;
        pend_d = 1'b1;
      end else begin
        flag_d = all_f;
      end
    end else if (to_q != TIMEOUT_CYC) begin
      to_d = to_q + 20'd1;
      if (to_d == TIMEOUT_CYC) begin
        lost_set = 1'b1;
        flag_d   = 4'd0;
      end
    end
  end

  assign ok = (slot_q[0] <= 4'd9) && (slot_q[1] <= 4'd9) &&
              (slot_q[2] <= 4'd9) && (slot_q[3] <= 4'd9);
  assign sec_c = ok ? 13'(slot_q[0]) * 13'd600 +
                      13'(slot_q[1]) * 13'd60 +
                      13'(slot_q[2]) * 13'd10 +
                      13'(slot_q[3])
                    : 13'd0;
  assign chg = first_q ||
    ({slot_q[0], slot_q[1], slot_q[2], slot_q[3]} !=
     {mh_q, ml_q, sh_q, sl_q});
  assign derr_c = (slot_q[0] >= 4'hE) || (slot_q[1] >= 4'hE) ||
                  (slot_q[2] >= 4'hE) || (slot_q[3] >= 4'hE) ||
                  (|sdp_q);

  // Frame state, error flags and committed outputs.
  always_ff @(posedge CLK) begin
    if (!RES_X) begin
      slot_q  <= '0;
      sdp_q   <= 4'd0;
      flag_q  <= 4'd0;
      pend_q  <= 1'b0;
      to_q    <= 20'd0;
      first_q <= 1'b1;
      mh_q    <= 4'hF;
      ml_q    <= 4'hF;
      sh_q    <= 4'hF;
      sl_q    <= 4'hF;
      sec_q   <= 13'd0;
      fv_q    <= 1'b0;
      vc_q    <= 1'b0;
      derr_q  <= 1'b0;
      serr_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      sdp_q  <= sdp_d;
      flag_q <= flag_d;
      pend_q <= pend_d;
      to_q   <= to_d;
      fv_q   <= pend_q;
      vc_q   <= pend_q && chg;
      serr_q <= serr_q | s_multi;
      if (pend_q) begin
        first_q <= 1'b0;
        mh_q    <= slot_q[0];
        ml_q    <= slot_q[1];
        sh_q    <= slot_q[2];
        sl_q    <= slot_q[3];
        sec_q   <= sec_c;
        derr_q  <= derr_c;
        lost_q  <= 1'b0;
      end else if (lost_set) begin
        lost_q <= 1'b1;
      end
    end
  end

  assign bus.M_HI          = mh_q;
  assign bus.M_LO          = ml_q;
  assign bus.S_HI          = sh_q;
  assign bus.S_LO          = sl_q;
  assign bus.SEC_TOTAL     = sec_q;
  assign bus.FRAME_VALID   = fv_q;
  assign bus.VALUE_CHANGED = vc_q;
  assign bus.DECODE_ERR    = derr_q;
  assign bus.SCAN_ERR      = serr_q;
  assign bus.SCAN_LOST     = lost_q;
endmodule

// File: tb/tb_seven_seg_scan_receiver.sv
// Bench for seven_seg_scan_receiver: run-length pin model plus
// directed display scans with hand-computed frame values.
module tb_seven_seg_scan_receiver;
  localparam int S = 4;
  localparam int T = 4096;
  localparam int DW = 244;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_seg_scan_receiver_if bus();

  seven_seg_scan_receiver #(
    .SETTLE_CYC(8'd4),
    .TIMEOUT_CYC(20'h01000),
    .SEG_ACTIVE(1'b1)
  ) dut (
    .CLK(clk),
    .RES_X(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int vc_cnt = 0;

  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic [3:0]  e_mh, e_ml, e_sh, e_sl;
  logic [12:0] e_sec;
  logic        e_fv, e_vc, e_de, e_se, e_sl_lost;
  logic [3:0]  m_slot [4];
  logic [3:0]  m_dp, m_flag;
  logic        m_pend, m_first, m_last_dp;
  int          m_since, m_run;
  logic [10:0] m_last;
  bit          started = 0;

  function automatic logic [3:0] mdec(input logic [6:0] s);
    logic [3:0] r;
    r = (s == 7'h00) ? 4'hF : 4'hE;
    for (int i = 0; i < 10; i++)
      if (segtab[i] == s) r = 4'(i);
    return r;
  endfunction

  // Model: a digit is taken once its one-hot pin picture has been
  // identical for exactly S+1 consecutive edges; frame commits next edge.
  always @(posedge clk) begin : model
    logic [10:0] cur;
    int n;
    int sec;
    bit ok;
    started = 1;
    cur = {bus.DIG_4, bus.DIG_3, bus.DIG_2, bus.DIG_1, bus.LIGHT_SEG};
    if (!rst_n) begin
      {e_mh, e_ml, e_sh, e_sl} = 16'hFFFF;
      e_sec = 0; e_fv = 0; e_vc = 0; e_de = 0; e_se = 0; e_sl_lost = 0;
      for (int i = 0; i < 4; i++) m_slot[i] = 4'd0;
      m_dp = 0; m_flag = 0; m_pend = 0; m_first = 1;
      m_since = 0; m_run = 1; m_last = 11'd0; m_last_dp = 0;
    end else begin
      e_fv = 0;
      e_vc = 0;
      if (m_pend) begin
        m_pend = 0;
        ok = 1;
        for (int i = 0; i < 4; i++) if (m_slot[i] > 9) ok = 0;
        sec = (m_slot[0] * 10 + m_slot[1]) * 60 + m_slot[2] * 10 + m_slot[3];
        e_sec = ok ? 13'(sec) : 13'd0;
        e_vc = m_first ||
          ({m_slot[0], m_slot[1], m_slot[2], m_slot[3]} !==
           {e_mh, e_ml, e_sh, e_sl});
        {e_mh, e_ml, e_sh, e_sl} = {m_slot[0], m_slot[1], m_slot[2], m_slot[3]};
        e_de = !ok || (m_dp != 0);
        e_fv = 1;
        e_sl_lost = 0;
        m_first = 0;
      end
      if ($countones(m_last[10:7]) > 1) e_se = 1;
      if ($countones(m_last[10:7]) == 1 && m_run == S + 1) begin
        n = 0;
        for (int i = 0; i < 4; i++) if (m_last[7+i]) n = i;
        m_slot[n] = mdec(m_last[6:0]);
        m_dp[n] = m_last_dp;
        m_flag[n] = 1;
        if (m_flag == 4'hF) begin
          m_flag = 0;
          m_pend = 1;
        end
        m_since = 0;
      end else if (m_since < T) begin
        m_since++;
        if (m_since == T) begin
          e_sl_lost = 1;
          m_flag = 0;
        end
      end
      if (cur == m_last) begin
        if (m_run < 100000) m_run++;
      end else begin
        m_run = 1;
      end
      m_last = cur;
      m_last_dp = bus.DP;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if ({bus.M_HI, bus.M_LO, bus.S_HI, bus.S_LO, bus.SEC_TOTAL,
           bus.FRAME_VALID, bus.VALUE_CHANGED, bus.DECODE_ERR,
           bus.SCAN_ERR, bus.SCAN_LOST} !==
          {e_mh, e_ml, e_sh, e_sl, e_sec, e_fv, e_vc, e_de, e_se,
           e_sl_lost}) begin
        errors++;
        $display("FAIL cycle t=%0t: got %h%h:%h%h sec=%0d fv=%b vc=%b de=%b se=%b sl=%b expected %h%h:%h%h sec=%0d fv=%b vc=%b de=%b se=%b sl=%b",
          $time, bus.M_HI, bus.M_LO, bus.S_HI, bus.S_LO, bus.SEC_TOTAL,
          bus.FRAME_VALID, bus.VALUE_CHANGED, bus.DECODE_ERR,
          bus.SCAN_ERR, bus.SCAN_LOST, e_mh, e_ml, e_sh, e_sl, e_sec,
          e_fv, e_vc, e_de, e_se, e_sl_lost);
      end
      if (bus.FRAME_VALID === 1'b1) fv_cnt++;
      if (bus.VALUE_CHANGED === 1'b1) vc_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic put(input logic [3:0] d, input logic [6:0] s,
                     input logic dp);
    bus.DIG_1 = d[0];
    bus.DIG_2 = d[1];
    bus.DIG_3 = d[2];
    bus.DIG_4 = d[3];
    bus.LIGHT_SEG = s;
    bus.DP = dp;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] a, input logic [6:0] b,
                      input logic [6:0] c, input logic [6:0] d,
                      input logic dp4);
    put(4'b0001, a, 1'b0); hold(DW);
    put(4'b0010, b, 1'b0); hold(DW);
    put(4'b0100, c, 1'b0); hold(DW);
    put(4'b1000, d, dp4);  hold(DW);
  endtask

  int fv_before;

  initial begin
    put(4'd0, 7'd0, 1'b0);
    rst_n = 1'b0;
    hold(3);
    chk("reset M_HI", 32'(bus.M_HI), 32'hF);
    chk("reset S_LO", 32'(bus.S_LO), 32'hF);
    chk("reset SEC", 32'(bus.SEC_TOTAL), 0);
    chk("reset flags", 32'({bus.FRAME_VALID, bus.VALUE_CHANGED,
        bus.DECODE_ERR, bus.SCAN_ERR, bus.SCAN_LOST}), 0);
    rst_n = 1'b1;
    hold(5);

    scan(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0);
    chk("1234 digits", 32'({bus.M_HI, bus.M_LO, bus.S_HI, bus.S_LO}),
        32'h1234);
    chk("1234 SEC", 32'(bus.SEC_TOTAL), 754);
    chk("1234 model SEC", 32'(e_sec), 754);
    chk("1234 DECODE_ERR", 32'(bus.DECODE_ERR), 0);
    chk("1234 fv count", fv_cnt, 1);
    chk("1234 vc count", vc_cnt, 1);

    scan(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0);
    chk("repeat fv count", fv_cnt, 2);
    chk("repeat vc count", vc_cnt, 1);
    scan(7'h06, 7'h5B, 7'h4F, 7'h4F, 1'b0);
    chk("1233 SEC", 32'(bus.SEC_TOTAL), 753);
    chk("1233 vc count", vc_cnt, 2);

    put(4'b0001, 7'h06, 1'b0); hold(DW);
    put(4'b0010, 7'h5B, 1'b0); hold(DW - 3);
    put(4'b0010, 7'h7F, 1'b0); hold(3);
    put(4'b0100, 7'h4F, 1'b0); hold(DW);
    put(4'b1000, 7'h66, 1'b0); hold(DW);
    chk("glitch M_LO", 32'(bus.M_LO), 2);
    chk("glitch fv count", fv_cnt, 4);

    put(4'b0110, 7'h5B, 1'b0); hold(1);
    put(4'b0000, 7'h00, 1'b0); hold(2);
    chk("multi SCAN_ERR", 32'(bus.SCAN_ERR), 1);
    scan(7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0);
    chk("0000 digits", 32'({bus.M_HI, bus.M_LO, bus.S_HI, bus.S_LO}), 0);
    chk("0000 SEC", 32'(bus.SEC_TOTAL), 0);
    chk("0000 SCAN_ERR sticky", 32'(bus.SCAN_ERR), 1);
    chk("0000 fv count", fv_cnt, 5);

    scan(7'h3F, 7'h3F, 7'h49, 7'h3F, 1'b0);
    chk("bad S_HI", 32'(bus.S_HI), 32'hE);
    chk("bad DECODE_ERR", 32'(bus.DECODE_ERR), 1);
    chk("bad SEC", 32'(bus.SEC_TOTAL), 0);

    scan(7'h3F, 7'h06, 7'h3F, 7'h3F, 1'b1);
    chk("dp SEC", 32'(bus.SEC_TOTAL), 60);
    chk("dp DECODE_ERR", 32'(bus.DECODE_ERR), 1);

    fv_before = fv_cnt;
    put(4'b0001, 7'h6D, 1'b0); hold(DW);
    put(4'b0010, 7'h6D, 1'b0); hold(DW);
    put(4'b0000, 7'h00, 1'b0); hold(T + 4);
    chk("timeout SCAN_LOST", 32'(bus.SCAN_LOST), 1);
    chk("timeout hold SEC", 32'(bus.SEC_TOTAL), 60);
    put(4'b0100, 7'h6D, 1'b0); hold(DW);
    put(4'b1000, 7'h6F, 1'b0); hold(DW);
    chk("partial discarded fv", fv_cnt, fv_before);
    chk("partial SCAN_LOST", 32'(bus.SCAN_LOST), 1);
    scan(7'h6F, 7'h6F, 7'h6D, 7'h6F, 1'b0);
    chk("9959 SEC", 32'(bus.SEC_TOTAL), 5999);
    chk("9959 model SEC", 32'(e_sec), 5999);
    chk("9959 SCAN_LOST", 32'(bus.SCAN_LOST), 0);

    put(4'b0001, 7'h06, 1'b0); hold(DW);
    put(4'b0010, 7'h5B, 1'b0); hold(100);
    rst_n = 1'b0;
    hold(2);
    chk("midreset digits", 32'({bus.M_HI, bus.M_LO, bus.S_HI, bus.S_LO}),
        32'hFFFF);
    chk("midreset SEC", 32'(bus.SEC_TOTAL), 0);
    chk("midreset flags", 32'({bus.DECODE_ERR, bus.SCAN_ERR,
        bus.SCAN_LOST}), 0);
    rst_n = 1'b1;
    fv_before = fv_cnt;
    hold(DW - 100);
    put(4'b0100, 7'h4F, 1'b0); hold(DW);
    put(4'b1000, 7'h66, 1'b0); hold(DW);
    chk("midreset no commit", fv_cnt, fv_before);
    chk("midreset M_HI", 32'(bus.M_HI), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
